// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch port, load/store port and memory bus around mem_port_arbiter.
// The slave modport is the arbiter's view; master is the CPU/memory side.
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_done;
  logic [DW-1:0] if_rdata;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt;
  logic          d_done;
  logic [DW-1:0] d_rdata;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          busy;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_gnt, if_done, if_rdata, d_gnt, d_done, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_gnt, if_done, if_rdata, d_gnt, d_done, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between the fetch and load/store ports, one transaction at a time.
// Define ARB_ROUND_ROBIN_EN to replace fixed data-over-fetch priority with round-robin arbitration.
module mem_port_arbiter #(
  parameter int AW  = 32,
  parameter int DW  = 32,
  parameter int LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave bus
);

  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          accept;
  logic          pick_d;
  logic          sel_d_q, sel_d_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;
  logic          if_gnt_q, if_gnt_d;
  logic          d_gnt_q, d_gnt_d;
  logic          if_done_q, if_done_d;
  logic          d_done_q, d_done_d;
  logic          mem_en_q, mem_en_d;
  logic          mem_we_q, mem_we_d;
  logic          busy_q, busy_d;

  assign accept = (state_q == IDLE) && (bus.if_req || bus.d_req);

`ifdef ARB_ROUND_ROBIN_EN
  // last_d_q set means data won the previous acceptance, so fetch wins the next tie.
  logic last_d_q, last_d_d;

  always_comb begin
    pick_d   = bus.d_req && (!bus.if_req || !last_d_q);
    last_d_d = accept ? pick_d : last_d_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_d_q <= 1'b0;
    else     last_d_q <= last_d_d;
  end
`else
  always_comb pick_d = bus.d_req;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = ACCESS;
          cnt_d   = CW'(LAT - 1);
        end
      end
      ACCESS: begin
        if (cnt_q == '0) state_d = RESP;
        else             cnt_d   = cnt_q - CW'(1);
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request fields are latched at acceptance so requesters may change them during ACCESS.
  always_comb begin
    sel_d_d    = sel_d_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    if (accept) begin
      sel_d_d = pick_d;
      we_d    = pick_d && bus.d_we;
      addr_d  = pick_d ? bus.d_addr : bus.if_addr;
      wdata_d = pick_d ? bus.d_wdata : '0;
    end
    if ((state_q == ACCESS) && (cnt_q == '0) && !we_q) begin
      if (sel_d_q) d_rdata_d  = bus.mem_rdata;
      else         if_rdata_d = bus.mem_rdata;
    end
  end

  always_comb begin
    if_gnt_d  = 1'b0;
    d_gnt_d   = 1'b0;
    if_done_d = 1'b0;
    d_done_d  = 1'b0;
    mem_en_d  = (state_d == ACCESS);
    mem_we_d  = (state_d == ACCESS) && we_d;
    busy_d    = (state_d != IDLE);
    if (accept) begin
      if_gnt_d = !pick_d;
      d_gnt_d  = pick_d;
    end
    if (state_d == RESP) begin
      if_done_d = !sel_d_q;
      d_done_d  = sel_d_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_d_q    <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      if_gnt_q   <= 1'b0;
      d_gnt_q    <= 1'b0;
      if_done_q  <= 1'b0;
      d_done_q   <= 1'b0;
      mem_en_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      sel_d_q    <= sel_d_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
      if_gnt_q   <= if_gnt_d;
      d_gnt_q    <= d_gnt_d;
      if_done_q  <= if_done_d;
      d_done_q   <= d_done_d;
      mem_en_q   <= mem_en_d;
      mem_we_q   <= mem_we_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.if_gnt    = if_gnt_q;
  assign bus.d_gnt     = d_gnt_q;
  assign bus.if_done   = if_done_q;
  assign bus.d_done    = d_done_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter: one LAT=2 instance and one LAT=1 instance.
// Contention expectations follow ARB_ROUND_ROBIN_EN when it is defined for the build.
module tb_mem_port_arbiter;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  mem_port_arbiter_if #(.AW(32), .DW(32)) bus2 ();
  mem_port_arbiter_if #(.AW(32), .DW(32)) bus1 ();

  mem_port_arbiter #(.AW(32), .DW(32), .LAT(2)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2));
  mem_port_arbiter #(.AW(32), .DW(32), .LAT(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++; if (bus2.busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b expected 0", bus2.busy); end
    checks++; if (bus2.mem_en !== 1'b0) begin failures++; $display("[TB] FAIL reset_mem_en: got %b expected 0", bus2.mem_en); end
    checks++; if ({bus2.if_gnt, bus2.d_gnt, bus2.if_done, bus2.d_done, bus2.mem_we} !== 5'b0) begin failures++; $display("[TB] FAIL reset_pulses: got %b expected 00000", {bus2.if_gnt, bus2.d_gnt, bus2.if_done, bus2.d_done, bus2.mem_we}); end
    checks++; if ({bus2.if_rdata, bus2.d_rdata} !== 64'h0) begin failures++; $display("[TB] FAIL reset_rdata: got %h expected 0", {bus2.if_rdata, bus2.d_rdata}); end
    checks++; if (bus2.mem_addr !== 32'h0) begin failures++; $display("[TB] FAIL reset_mem_addr: got %h expected 0", bus2.mem_addr); end
    checks++; if ({bus1.busy, bus1.mem_en, bus1.d_rdata} !== 34'h0) begin failures++; $display("[TB] FAIL reset_lat1: got %h expected 0", {bus1.busy, bus1.mem_en, bus1.d_rdata}); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_fetch();
    bus2.mem_rdata = 32'hDEADBEEF;
    bus2.if_addr   = 32'h40;
    bus2.if_req    = 1'b1;
    tick();
    bus2.if_req  = 1'b0;
    bus2.if_addr = 32'h0;
    checks++; if (bus2.if_gnt !== 1'b1) begin failures++; $display("[TB] FAIL fetch_gnt: got %b expected 1", bus2.if_gnt); end
    checks++; if (bus2.d_gnt !== 1'b0) begin failures++; $display("[TB] FAIL fetch_d_gnt: got %b expected 0", bus2.d_gnt); end
    checks++; if ({bus2.mem_en, bus2.mem_we, bus2.mem_addr} !== {2'b10, 32'h40}) begin failures++; $display("[TB] FAIL fetch_access1: got en=%b we=%b addr=%h expected en=1 we=0 addr=40", bus2.mem_en, bus2.mem_we, bus2.mem_addr); end
    tick();
    checks++; if ({bus2.if_gnt, bus2.mem_en, bus2.mem_addr} !== {2'b01, 32'h40}) begin failures++; $display("[TB] FAIL fetch_access2: got gnt=%b en=%b addr=%h expected gnt=0 en=1 addr=40", bus2.if_gnt, bus2.mem_en, bus2.mem_addr); end
    tick();
    checks++; if ({bus2.if_done, bus2.d_done, bus2.mem_en} !== 3'b100) begin failures++; $display("[TB] FAIL fetch_done: got if_done=%b d_done=%b en=%b expected 1 0 0", bus2.if_done, bus2.d_done, bus2.mem_en); end
    checks++; if (bus2.if_rdata !== 32'hDEADBEEF) begin failures++; $display("[TB] FAIL fetch_rdata: got %h expected deadbeef", bus2.if_rdata); end
    tick();
    checks++; if ({bus2.busy, bus2.if_done} !== 2'b00) begin failures++; $display("[TB] FAIL fetch_idle: got busy=%b done=%b expected 0 0", bus2.busy, bus2.if_done); end
  endtask

  task automatic test_load();
    bus2.mem_rdata = 32'hCAFEF00D;
    bus2.d_addr    = 32'h80;
    bus2.d_we      = 1'b0;
    bus2.d_req     = 1'b1;
    tick();
    bus2.d_req = 1'b0;
    checks++; if ({bus2.d_gnt, bus2.if_gnt, bus2.mem_en, bus2.mem_we} !== 4'b1010) begin failures++; $display("[TB] FAIL load_gnt: got %b expected 1010", {bus2.d_gnt, bus2.if_gnt, bus2.mem_en, bus2.mem_we}); end
    tick();
    tick();
    checks++; if ({bus2.d_done, bus2.if_done} !== 2'b10) begin failures++; $display("[TB] FAIL load_done: got %b expected 10", {bus2.d_done, bus2.if_done}); end
    checks++; if (bus2.d_rdata !== 32'hCAFEF00D) begin failures++; $display("[TB] FAIL load_rdata: got %h expected cafef00d", bus2.d_rdata); end
    checks++; if (bus2.if_rdata !== 32'hDEADBEEF) begin failures++; $display("[TB] FAIL load_if_rdata_hold: got %h expected deadbeef", bus2.if_rdata); end
    tick();
  endtask

  task automatic test_store();
    bus2.mem_rdata = 32'hBADBAD00;
    bus2.d_addr    = 32'h100;
    bus2.d_wdata   = 32'h12345678;
    bus2.d_we      = 1'b1;
    bus2.d_req     = 1'b1;
    tick();
    bus2.d_req   = 1'b0;
    bus2.d_we    = 1'b0;
    bus2.d_wdata = 32'h0;
    bus2.d_addr  = 32'h0;
    checks++; if ({bus2.d_gnt, bus2.mem_en, bus2.mem_we} !== 3'b111) begin failures++; $display("[TB] FAIL store_access1: got gnt/en/we=%b expected 111", {bus2.d_gnt, bus2.mem_en, bus2.mem_we}); end
    checks++; if ({bus2.mem_addr, bus2.mem_wdata} !== {32'h100, 32'h12345678}) begin failures++; $display("[TB] FAIL store_bus: got addr=%h wdata=%h expected 100 12345678", bus2.mem_addr, bus2.mem_wdata); end
    tick();
    checks++; if ({bus2.d_gnt, bus2.mem_en, bus2.mem_we, bus2.mem_wdata} !== {3'b011, 32'h12345678}) begin failures++; $display("[TB] FAIL store_access2: got gnt/en/we=%b wdata=%h expected 011 12345678", {bus2.d_gnt, bus2.mem_en, bus2.mem_we}, bus2.mem_wdata); end
    tick();
    checks++; if ({bus2.d_done, bus2.mem_en, bus2.mem_we} !== 3'b100) begin failures++; $display("[TB] FAIL store_done: got done/en/we=%b expected 100", {bus2.d_done, bus2.mem_en, bus2.mem_we}); end
    checks++; if (bus2.d_rdata !== 32'hCAFEF00D) begin failures++; $display("[TB] FAIL store_rdata_hold: got %h expected cafef00d", bus2.d_rdata); end
    tick();
  endtask

  task automatic test_back_to_back();
    int   n_gnt;
    int   last_cyc;
    int   waited;
    logic exp_d;
    logic seen_d;
    do_reset();
    bus2.mem_rdata = 32'h11112222;
    bus2.if_addr   = 32'h10;
    bus2.d_addr    = 32'h20;
    bus2.d_we      = 1'b0;
    bus2.if_req    = 1'b1;
    bus2.d_req     = 1'b1;
    n_gnt    = 0;
    last_cyc = 0;
    for (int cyc = 1; cyc <= 40 && n_gnt < 4; cyc++) begin
      tick();
      if (bus2.if_gnt || bus2.d_gnt) begin
`ifdef ARB_ROUND_ROBIN_EN
        exp_d = (n_gnt % 2) == 0;
`else
        exp_d = 1'b1;
`endif
        checks++; if ({bus2.d_gnt, bus2.if_gnt} !== {exp_d, !exp_d}) begin failures++; $display("[TB] FAIL contention_order[%0d]: got d_gnt=%b if_gnt=%b expected d_gnt=%b", n_gnt, bus2.d_gnt, bus2.if_gnt, exp_d); end
        if (n_gnt > 0) begin
          checks++; if (cyc - last_cyc !== 4) begin failures++; $display("[TB] FAIL contention_gap[%0d]: got %0d cycles expected 4", n_gnt, cyc - last_cyc); end
        end
        last_cyc = cyc;
        n_gnt++;
      end
    end
    checks++; if (n_gnt !== 4) begin failures++; $display("[TB] FAIL contention_timeout: got %0d grants expected 4", n_gnt); end
    bus2.d_req = 1'b0;
    seen_d = 1'b0;
    waited = 0;
    while (waited < 20 && !bus2.if_gnt) begin
      tick();
      waited++;
      if (bus2.d_gnt) seen_d = 1'b1;
    end
    bus2.if_req = 1'b0;
    checks++; if ({bus2.if_gnt, seen_d} !== 2'b10) begin failures++; $display("[TB] FAIL fetch_after_drop: got if_gnt=%b stray_d_gnt=%b expected 1 0", bus2.if_gnt, seen_d); end
    tick();
    tick();
    tick();
    checks++; if (bus2.busy !== 1'b0) begin failures++; $display("[TB] FAIL contention_idle: got busy=%b expected 0", bus2.busy); end
  endtask

  task automatic test_reset_mid_access();
    int   waited;
    logic stray_done;
    bus2.mem_rdata = 32'h0BADF00D;
    bus2.if_addr   = 32'h200;
    bus2.if_req    = 1'b1;
    tick();
    bus2.if_req = 1'b0;
    tick();
    checks++; if (bus2.mem_en !== 1'b1) begin failures++; $display("[TB] FAIL midreset_pre_en: got %b expected 1", bus2.mem_en); end
    rst = 1'b1;
    #1;
    checks++; if ({bus2.mem_en, bus2.busy} !== 2'b00) begin failures++; $display("[TB] FAIL midreset_async: got en=%b busy=%b expected 0 0", bus2.mem_en, bus2.busy); end
    stray_done = 1'b0;
    tick();
    if (bus2.if_done || bus2.d_done) stray_done = 1'b1;
    rst = 1'b0;
    tick();
    if (bus2.if_done || bus2.d_done) stray_done = 1'b1;
    tick();
    if (bus2.if_done || bus2.d_done) stray_done = 1'b1;
    checks++; if (stray_done !== 1'b0) begin failures++; $display("[TB] FAIL midreset_no_done: got stray done=%b expected 0", stray_done); end
    bus2.if_addr = 32'h300;
    bus2.if_req  = 1'b1;
    tick();
    bus2.if_req = 1'b0;
    checks++; if ({bus2.if_gnt, bus2.mem_addr} !== {1'b1, 32'h300}) begin failures++; $display("[TB] FAIL midreset_regnt: got gnt=%b addr=%h expected 1 300", bus2.if_gnt, bus2.mem_addr); end
    waited = 1;
    while (waited < 10 && !bus2.if_done) begin
      tick();
      waited++;
    end
    checks++; if (waited !== 3) begin failures++; $display("[TB] FAIL midreset_latency: got done after %0d cycles expected 3", waited); end
    checks++; if (bus2.if_rdata !== 32'h0BADF00D) begin failures++; $display("[TB] FAIL midreset_rdata: got %h expected 0badf00d", bus2.if_rdata); end
    tick();
  endtask

  task automatic test_lat1();
    bus1.mem_rdata = 32'h55AA1234;
    bus1.d_addr    = 32'h44;
    bus1.d_we      = 1'b0;
    bus1.d_req     = 1'b1;
    tick();
    bus1.d_req = 1'b0;
    checks++; if ({bus1.d_gnt, bus1.mem_en, bus1.mem_we, bus1.mem_addr} !== {3'b110, 32'h44}) begin failures++; $display("[TB] FAIL lat1_access: got gnt/en/we=%b addr=%h expected 110 44", {bus1.d_gnt, bus1.mem_en, bus1.mem_we}, bus1.mem_addr); end
    tick();
    checks++; if ({bus1.d_done, bus1.d_gnt, bus1.mem_en, bus1.if_done} !== 4'b1000) begin failures++; $display("[TB] FAIL lat1_done: got done/gnt/en/if_done=%b expected 1000", {bus1.d_done, bus1.d_gnt, bus1.mem_en, bus1.if_done}); end
    checks++; if (bus1.d_rdata !== 32'h55AA1234) begin failures++; $display("[TB] FAIL lat1_rdata: got %h expected 55aa1234", bus1.d_rdata); end
    tick();
    checks++; if ({bus1.busy, bus1.d_done} !== 2'b00) begin failures++; $display("[TB] FAIL lat1_idle: got busy/done=%b expected 00", {bus1.busy, bus1.d_done}); end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks         = 0;
    failures       = 0;
    rst            = 1'b1;
    bus2.if_req    = 1'b0;
    bus2.if_addr   = '0;
    bus2.d_req     = 1'b0;
    bus2.d_we      = 1'b0;
    bus2.d_addr    = '0;
    bus2.d_wdata   = '0;
    bus2.mem_rdata = '0;
    bus1.if_req    = 1'b0;
    bus1.if_addr   = '0;
    bus1.d_req     = 1'b0;
    bus1.d_we      = 1'b0;
    bus1.d_addr    = '0;
    bus1.d_wdata   = '0;
    bus1.mem_rdata = '0;
    test_reset();
    test_fetch();
    test_load();
    test_store();
    test_back_to_back();
    test_reset_mid_access();
    test_lat1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
